noc_vc_credit_ctrl: RTL and testbench

// - Output-port flow-control tracker for the NoC router, generalised to NumVc virtual channels.
// - Supports two runtime-fixed modes:
//   - credit-based: one credit counter per VC.
//   - ack/nack: ready passthrough.
// - Tracks packet framing per VC (head/tail) and flags protocol violations.
// - One instance sits on each router output port, between switch allocation and the link.

---
 rtl/noc_vc_credit_ctrl.sv | 138 +++++++++++++
 tb/tb_noc_vc_credit_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_vc_credit_ctrl.sv
// ============================================================================
// noc_vc_credit_ctrl: per-VC credit / ack-nack flow control with framing checks
// Revision: 1.0
// ============================================================================
`default_nettype none

package noc_vc_credit_ctrl_pkg;
  typedef enum logic [0:0] {
    kFlowControlCreditBased = 1'b0,
    kFlowControlAckNack     = 1'b1
  } noc_flow_control_t;
endpackage

module noc_vc_credit_ctrl
  import noc_vc_credit_ctrl_pkg::*;
#(
  parameter int unsigned       NumVc          = 2,
  parameter int unsigned       PortQueueDepth = 4,
  parameter noc_flow_control_t FlowControl    = kFlowControlCreditBased,
  parameter int unsigned       CreditsWidth   = $clog2(PortQueueDepth + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NumVc-1:0]              send_i,
  input  logic [1:0]                    preamble_i,
  input  logic [NumVc-1:0]              credit_i,
  input  logic                          err_clr_i,
  output logic [NumVc-1:0]              avail_o,
  output logic [NumVc*CreditsWidth-1:0] credits_o,
  output logic [NumVc-1:0]              vc_busy_o,
  output logic                          err_ovf_o,
  output logic                          err_unf_o,
  output logic                          err_frm_o
);

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } vc_state_e;

  localparam bit                      CreditMode   = (FlowControl == kFlowControlCreditBased);
  localparam logic [CreditsWidth:0]   DepthExt     = (CreditsWidth + 1)'(PortQueueDepth);
  localparam logic [CreditsWidth-1:0] ResetCredits = CreditMode ? CreditsWidth'(PortQueueDepth) : '0;

  logic       head, tail;
  logic [NumVc-1:0] ovf_vc, unf_vc, frm_vc;
  logic       multi_send;
  logic       err_ovf_q, err_ovf_d;
  logic       err_unf_q, err_unf_d;
  logic       err_frm_q, err_frm_d;

  assign head       = preamble_i[1];
  assign tail       = preamble_i[0];
  assign multi_send = ($countones(send_i) > 1);

  for (genvar v = 0; v < NumVc; v++) begin : g_vc
    logic [CreditsWidth-1:0] cnt_q, cnt_d;
    logic [CreditsWidth:0]   sum;
    vc_state_e               state_q, state_d;
    logic                    ovf, unf, frm;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q   <= ResetCredits;
        state_q <= StIdle;
      end else begin
        cnt_q   <= cnt_d;
        state_q <= state_d;
      end
    end

    // Extra headroom bit lets the sum exceed the depth before clamping.
    always_comb begin
      sum   = {1'b0, cnt_q} + {{CreditsWidth{1'b0}}, credit_i[v]};
      cnt_d = cnt_q;
      ovf   = 1'b0;
      unf   = 1'b0;
      if (CreditMode) begin
        if (send_i[v]) begin
          unf = (cnt_q == '0);
          if (sum != '0) begin
            sum = sum - 1'b1;
          end
        end
        if (sum > DepthExt) begin
          sum = DepthExt;
          ovf = 1'b1;
        end
        cnt_d = sum[CreditsWidth-1:0];
      end else begin
        unf = send_i[v] & ~credit_i[v];
      end
    end

    // Framing state always follows the flit, even when it is a violation.
    always_comb begin
      state_d = state_q;
      frm     = 1'b0;
      if (send_i[v]) begin
        state_d = tail ? StIdle : StBusy;
        frm     = head ? (state_q == StBusy) : (state_q == StIdle);
      end
    end

    assign ovf_vc[v]    = ovf;
    assign unf_vc[v]    = unf;
    assign frm_vc[v]    = frm;
    assign avail_o[v]   = CreditMode ? (cnt_q != '0) : credit_i[v];
    assign vc_busy_o[v] = (state_q == StBusy);
    assign credits_o[v*CreditsWidth +: CreditsWidth] = cnt_q;
  end

  // A fresh error beats a simultaneous clear.
  always_comb begin
    err_ovf_d = (err_ovf_q & ~err_clr_i) | (|ovf_vc);
    err_unf_d = (err_unf_q & ~err_clr_i) | (|unf_vc);
    err_frm_d = (err_frm_q & ~err_clr_i) | (|frm_vc) | multi_send;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      err_frm_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
      err_frm_q <= err_frm_d;
    end
  end

  assign err_ovf_o = err_ovf_q;
  assign err_unf_o = err_unf_q;
  assign err_frm_o = err_frm_q;

endmodule

`default_nettype wire

// File: tb/tb_noc_vc_credit_ctrl.sv
// ============================================================================
// tb_noc_vc_credit_ctrl: credit-mode and ack/nack-mode instances checked
// against a behavioural model plus directed literal expectations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_noc_vc_credit_ctrl;
  localparam int NV = 2;
  localparam int D  = 4;
  localparam int W  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NV-1:0] send;
  logic [1:0]    pre;
  logic [NV-1:0] credit;
  logic          err_clr;

  logic [NV-1:0]   avail_c, busy_c, avail_a, busy_a;
  logic [NV*W-1:0] credits_c, credits_a;
  logic            ovf_c, unf_c, frm_c, ovf_a, unf_a, frm_a;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  noc_vc_credit_ctrl #(
    .NumVc(NV), .PortQueueDepth(D),
    .FlowControl(noc_vc_credit_ctrl_pkg::kFlowControlCreditBased)
  ) dut_c (
    .clk(clk), .rst(rst), .send_i(send), .preamble_i(pre), .credit_i(credit),
    .err_clr_i(err_clr), .avail_o(avail_c), .credits_o(credits_c),
    .vc_busy_o(busy_c), .err_ovf_o(ovf_c), .err_unf_o(unf_c), .err_frm_o(frm_c)
  );

  noc_vc_credit_ctrl #(
    .NumVc(NV), .PortQueueDepth(D),
    .FlowControl(noc_vc_credit_ctrl_pkg::kFlowControlAckNack)
  ) dut_a (
    .clk(clk), .rst(rst), .send_i(send), .preamble_i(pre), .credit_i(credit),
    .err_clr_i(err_clr), .avail_o(avail_a), .credits_o(credits_a),
    .vc_busy_o(busy_a), .err_ovf_o(ovf_a), .err_unf_o(unf_a), .err_frm_o(frm_a)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer credit counts, packet-open flags, sticky errors.
  int m_cnt [NV];
  bit m_busy[NV];
  bit m_ovf, m_unf_c, m_unf_a, m_frm;

  always @(posedge clk or negedge rst) begin : b_model
    int c;
    bit o, uc, ua, f;
    if (!rst) begin
      for (int v = 0; v < NV; v++) begin
        m_cnt[v]  <= D;
        m_busy[v] <= 1'b0;
      end
      m_ovf   <= 1'b0;
      m_unf_c <= 1'b0;
      m_unf_a <= 1'b0;
      m_frm   <= 1'b0;
    end else begin
      o  = 1'b0;
      uc = 1'b0;
      ua = 1'b0;
      f  = ($countones(send) > 1);
      for (int v = 0; v < NV; v++) begin
        c = m_cnt[v] + int'(credit[v]) - int'(send[v]);
        if (send[v] && m_cnt[v] == 0) uc = 1'b1;
        if (send[v] && !credit[v])    ua = 1'b1;
        if (c < 0) c = 0;
        if (c > D) begin
          c = D;
          o = 1'b1;
        end
        m_cnt[v] <= c;
        if (send[v]) begin
          if (pre[1] && m_busy[v])   f = 1'b1;
          if (!pre[1] && !m_busy[v]) f = 1'b1;
          m_busy[v] <= !pre[0];
        end
      end
      m_ovf   <= o  | (m_ovf   & !err_clr);
      m_unf_c <= uc | (m_unf_c & !err_clr);
      m_unf_a <= ua | (m_unf_a & !err_clr);
      m_frm   <= f  | (m_frm   & !err_clr);
    end
  end

  always @(negedge clk) begin : b_compare
    logic [NV*W-1:0] e_cred;
    logic [NV-1:0]   e_avail, e_busy;
    for (int v = 0; v < NV; v++) begin
      e_cred[v*W +: W] = W'(m_cnt[v]);
      e_avail[v]       = (m_cnt[v] != 0);
      e_busy[v]        = m_busy[v];
    end
    chk("m_credits_c", credits_c, e_cred);
    chk("m_avail_c",   avail_c,   e_avail);
    chk("m_busy_c",    busy_c,    e_busy);
    chk("m_ovf_c",     ovf_c,     m_ovf);
    chk("m_unf_c",     unf_c,     m_unf_c);
    chk("m_frm_c",     frm_c,     m_frm);
    chk("m_credits_a", credits_a, 0);
    chk("m_avail_a",   avail_a,   credit);
    chk("m_busy_a",    busy_a,    e_busy);
    chk("m_ovf_a",     ovf_a,     0);
    chk("m_unf_a",     unf_a,     m_unf_a);
    chk("m_frm_a",     frm_a,     m_frm);
  end

  task automatic step(input logic [1:0] s, input logic [1:0] p,
                      input logic [1:0] c, input logic clr_in);
    @(posedge clk);
    #1;
    send    = s;
    pre     = p;
    credit  = c;
    err_clr = clr_in;
  endtask

  initial begin
    send    = '0;
    pre     = '0;
    credit  = '0;
    err_clr = 1'b0;
    rst     = 1'b1;
    #1 rst  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_credits_c", credits_c, 6'h24);
    chk("rst_avail_c",   avail_c,   2'b11);
    chk("rst_busy_c",    busy_c,    2'b00);
    chk("rst_errs_c",    {ovf_c, unf_c, frm_c}, 3'b000);
    chk("rst_credits_a", credits_a, 6'h00);
    chk("rst_avail_a",   avail_a,   2'b00);
    @(negedge clk);
    rst = 1'b1;

    // Drain VC0, then one credit back
    step(2'b01, 2'b11, 2'b00, 1'b0);
    step(2'b01, 2'b11, 2'b00, 1'b0); chk("drain_cnt3", credits_c[2:0], 3);
    step(2'b01, 2'b11, 2'b00, 1'b0); chk("drain_cnt2", credits_c[2:0], 2);
    step(2'b01, 2'b11, 2'b00, 1'b0); chk("drain_cnt1", credits_c[2:0], 1);
    step(2'b00, 2'b00, 2'b01, 1'b0);
    chk("drain_cnt0", credits_c[2:0], 0);
    chk("drain_avail0", avail_c[0], 1'b0);
    step(2'b00, 2'b00, 2'b00, 1'b0);
    chk("ret_cnt1", credits_c[2:0], 1);
    chk("ret_avail1", avail_c[0], 1'b1);
    step(2'b00, 2'b00, 2'b00, 1'b1);
    step(2'b00, 2'b00, 2'b00, 1'b0); chk("clr_unf_a", unf_a, 1'b0);

    // VC1: simultaneous send+credit, then overflow and clear
    step(2'b10, 2'b11, 2'b00, 1'b0);
    step(2'b10, 2'b11, 2'b00, 1'b0); chk("vc1_cnt3", credits_c[5:3], 3);
    step(2'b10, 2'b11, 2'b10, 1'b0); chk("vc1_cnt2", credits_c[5:3], 2);
    step(2'b00, 2'b00, 2'b00, 1'b0);
    chk("sc_cnt2", credits_c[5:3], 2);
    chk("sc_noerr", {ovf_c, unf_c}, 2'b00);
    step(2'b00, 2'b00, 2'b10, 1'b0);
    step(2'b00, 2'b00, 2'b10, 1'b0); chk("vc1_back3", credits_c[5:3], 3);
    step(2'b00, 2'b00, 2'b10, 1'b0);
    chk("vc1_full4", credits_c[5:3], 4);
    chk("full_no_ovf", ovf_c, 1'b0);
    step(2'b00, 2'b00, 2'b00, 1'b0);
    chk("sat_cnt4", credits_c[5:3], 4);
    chk("ovf_set", ovf_c, 1'b1);
    step(2'b00, 2'b00, 2'b00, 1'b1);
    step(2'b00, 2'b00, 2'b00, 1'b0); chk("ovf_clr", ovf_c, 1'b0);

    // Framing on VC0
    step(2'b00, 2'b00, 2'b01, 1'b0);
    step(2'b00, 2'b00, 2'b01, 1'b0);
    step(2'b00, 2'b00, 2'b01, 1'b0);
    step(2'b01, 2'b10, 2'b00, 1'b0);
    step(2'b01, 2'b00, 2'b00, 1'b0); chk("frm_head_busy", busy_c[0], 1'b1);
    step(2'b01, 2'b01, 2'b00, 1'b0); chk("frm_body_busy", busy_c[0], 1'b1);
    step(2'b01, 2'b11, 2'b00, 1'b0);
    chk("frm_tail_idle", busy_c[0], 1'b0);
    chk("frm_ok", frm_c, 1'b0);
    step(2'b01, 2'b00, 2'b00, 1'b0);
    chk("frm_single_idle", busy_c[0], 1'b0);
    chk("frm_single_ok", frm_c, 1'b0);
    step(2'b00, 2'b00, 2'b00, 1'b0); chk("frm_body_in_idle", frm_c, 1'b1);
    step(2'b01, 2'b01, 2'b00, 1'b0);

    // Multi-bit send
    step(2'b00, 2'b00, 2'b01, 1'b0);
    step(2'b00, 2'b00, 2'b01, 1'b0);
    step(2'b00, 2'b00, 2'b00, 1'b1);
    step(2'b00, 2'b00, 2'b00, 1'b0); chk("multi_pre", {ovf_c, unf_c, frm_c}, 3'b000);
    step(2'b11, 2'b11, 2'b11, 1'b0);
    step(2'b00, 2'b00, 2'b00, 1'b0);
    chk("multi_frm", frm_c, 1'b1);
    chk("multi_cnt", credits_c, 6'h22);

    // Ack/nack instance
    step(2'b00, 2'b00, 2'b01, 1'b1);
    chk("ack_avail", avail_a, 2'b01);
    chk("ack_credits", credits_a, 6'h00);
    step(2'b10, 2'b11, 2'b01, 1'b0); chk("ack_unf_pre", unf_a, 1'b0);
    step(2'b00, 2'b00, 2'b00, 1'b0);
    chk("ack_unf", unf_a, 1'b1);
    chk("ack_no_ovf", ovf_a, 1'b0);

    // Asynchronous reset mid-packet
    step(2'b10, 2'b10, 2'b00, 1'b0);
    step(2'b10, 2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 2'b00, 1'b0);
    chk("pre_rst_cnt1", credits_c[5:3], 1);
    chk("pre_rst_busy1", busy_c[1], 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy_c, 2'b00);
    chk("arst_credits", credits_c, 6'h24);
    chk("arst_avail", avail_c, 2'b11);
    chk("arst_errs", {ovf_c, unf_c, frm_c}, 3'b000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step(2'b00, 2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 2'b00, 1'b0);
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
